// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Holds the register/data widths, reset/enable encodings, the default
// starvation limit, the async source encoding and the write-port record.
package regfile_wb_arbiter_pkg;

   localparam int RegAddrW = 5;
   localparam int RegW     = 32;

   localparam logic [RegAddrW-1:0] NOPRegAddr = '0;
   localparam logic [RegW-1:0]     ZeroWord   = '0;
   localparam logic                WriteEnable  = 1'b1;
   localparam logic                WriteDisable = 1'b0;
   localparam logic                RstEnable    = 1'b1;

   localparam int StarveLimitDefault = 4;

   // Async writeback sources, also the round-robin pointer encoding.
   typedef enum logic {
      SRC_LD = 1'b0,
      SRC_MD = 1'b1
   } src_e;

   // One register-file write port: enable, destination, data.
   typedef struct packed {
      logic                we;
      logic [RegAddrW-1:0] addr;
      logic [RegW-1:0]     data;
   } wr_t;

   localparam wr_t WrIdle = '{we: WriteDisable, addr: NOPRegAddr, data: ZeroWord};

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter for the async writeback sources.
// Latency: grants are combinational; the pointer updates at the clock edge.
// Backpressure: with two free ports both requesters win; with one free port
// and both requesting, the pointer picks and then flips; with none, no grant.
// Ports: clk, rst (sync, active-high), req0 (ld) / req1 (md) requests,
// free_ports (0..2 write ports left after the pipe), gnt0 / gnt1 grants.
module regfile_wb_arbiter_rr_arb2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] free_ports,
   output logic       gnt0,
   output logic       gnt1
);

   src_e ptr;
   logic contend;

   always_comb begin
      contend = req0 & req1 & (free_ports == 2'd1);
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      // No grants while in reset so pending requests survive it untouched.
      if (rst != RstEnable) begin
         if (free_ports >= 2'd2) begin
            gnt0 = req0;
            gnt1 = req1;
         end else if (free_ports == 2'd1) begin
            if (contend) begin
               gnt0 = (ptr == SRC_LD);
               gnt1 = (ptr == SRC_MD);
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
         end
      end
   end

   // Only a contended grant moves the pointer.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         ptr <= SRC_LD;
      end else if (contend) begin
         ptr <= (ptr == SRC_LD) ? SRC_MD : SRC_LD;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Schedules the two regfile write ports among pipe slots 0/1 and the ld/md async units.
// Latency: one cycle from acceptance to the registered we/waddr/wdata outputs.
// Backpressure: pipe never waits (except the one-cycle stall_req); async sources
// see ready=0 when no port is left, and starvation forces a one-cycle stall.
// Ports: clk, rst (sync, active-high); p0_*/p1_* pipe writes; ld_*/md_* async
// valid/ready writes; stall_req; we1/waddr1/wdata1 (older) and we2/waddr2/wdata2
// (younger, wins on same-address writes).
// Build option WB_ZERO_FILTER_EN: requests to register 0 are accepted without
// taking a port or driving a write enable.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = StarveLimitDefault,
   parameter int CNT_W        = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                p0_we,
   input  logic [RegAddrW-1:0] p0_waddr,
   input  logic [RegW-1:0]     p0_wdata,
   input  logic                p1_we,
   input  logic [RegAddrW-1:0] p1_waddr,
   input  logic [RegW-1:0]     p1_wdata,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [RegAddrW-1:0] ld_waddr,
   input  logic [RegW-1:0]     ld_wdata,
   input  logic                md_valid,
   output logic                md_ready,
   input  logic [RegAddrW-1:0] md_waddr,
   input  logic [RegW-1:0]     md_wdata,
   output logic                stall_req,
   output logic                we1,
   output logic [RegAddrW-1:0] waddr1,
   output logic [RegW-1:0]     wdata1,
   output logic                we2,
   output logic [RegAddrW-1:0] waddr2,
   output logic [RegW-1:0]     wdata2
);

   wr_t              port1_q, port2_q, port1_nxt, port2_nxt;
   wr_t              w_p0, w_p1, w_ld, w_md;
   logic             stall_q;
   logic [CNT_W-1:0] cnt_q;

   logic       p0_use, p1_use;   // pipe writes that take a port
   logic       ld_zero, md_zero; // async writes to r0 absorbed without a port
   logic       ld_req, md_req;   // async writes that compete for a port
   logic       ld_gnt, md_gnt;
   logic [1:0] free_ports;
   logic       starve, hit;

   assign w_p0 = '{we: WriteEnable, addr: p0_waddr, data: p0_wdata};
   assign w_p1 = '{we: WriteEnable, addr: p1_waddr, data: p1_wdata};
   assign w_ld = '{we: WriteEnable, addr: ld_waddr, data: ld_wdata};
   assign w_md = '{we: WriteEnable, addr: md_waddr, data: md_wdata};

`ifdef WB_ZERO_FILTER_EN
   assign p0_use  = p0_we & ~stall_q & (p0_waddr != NOPRegAddr);
   assign p1_use  = p1_we & ~stall_q & (p1_waddr != NOPRegAddr);
   assign ld_zero = ld_valid & (ld_waddr == NOPRegAddr);
   assign md_zero = md_valid & (md_waddr == NOPRegAddr);
`else
   assign p0_use  = p0_we & ~stall_q;
   assign p1_use  = p1_we & ~stall_q;
   assign ld_zero = 1'b0;
   assign md_zero = 1'b0;
`endif

   assign ld_req     = ld_valid & ~ld_zero;
   assign md_req     = md_valid & ~md_zero;
   assign free_ports = 2'd2 - {1'b0, p0_use} - {1'b0, p1_use};

   regfile_wb_arbiter_rr_arb2 u_rr (
      .clk        (clk),
      .rst        (rst),
      .req0       (ld_req),
      .req1       (md_req),
      .free_ports (free_ports),
      .gnt0       (ld_gnt),
      .gnt1       (md_gnt)
   );

   assign ld_ready = ld_gnt | (ld_zero & (rst != RstEnable));
   assign md_ready = md_gnt | (md_zero & (rst != RstEnable));

   // Port 1 takes the first, port 2 the second of: ld, md, p0, p1. This puts
   // async results on port 1 so a same-cycle pipe write overrides on port 2.
   always_comb begin
      port1_nxt = WrIdle;
      port2_nxt = WrIdle;
      if (ld_gnt) begin
         port1_nxt = w_ld;
         if (md_gnt)      port2_nxt = w_md;
         else if (p0_use) port2_nxt = w_p0;
         else if (p1_use) port2_nxt = w_p1;
      end else if (md_gnt) begin
         port1_nxt = w_md;
         if (p0_use)      port2_nxt = w_p0;
         else if (p1_use) port2_nxt = w_p1;
      end else if (p0_use) begin
         port1_nxt = w_p0;
         if (p1_use)      port2_nxt = w_p1;
      end else if (p1_use) begin
         port1_nxt = w_p1;
      end
   end

   // A starved cycle that would bring the count to the limit raises
   // stall_req instead; the counter clears in the same step.
   assign starve = (ld_valid | md_valid) & ~(ld_ready | md_ready);
   assign hit    = starve & ~stall_q & (cnt_q == CNT_W'(STARVE_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         port1_q <= WrIdle;
         port2_q <= WrIdle;
         stall_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         port1_q <= port1_nxt;
         port2_q <= port2_nxt;
         stall_q <= hit;
         if (!starve || hit) begin
            cnt_q <= '0;
         end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_req = stall_q;
   assign we1       = port1_q.we;
   assign waddr1    = port1_q.addr;
   assign wdata1    = port1_q.data;
   assign we2       = port2_q.we;
   assign waddr2    = port2_q.addr;
   assign wdata2    = port2_q.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then randomized traffic,
// with expected port outputs queued by a reference model and checked by a monitor.
module tb_regfile_wb_arbiter;

   localparam int LIMIT = 4;
`ifdef WB_ZERO_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_we, p1_we, ld_valid, md_valid;
   logic [4:0]  p0_waddr, p1_waddr, ld_waddr, md_waddr;
   logic [31:0] p0_wdata, p1_wdata, ld_wdata, md_wdata;
   logic        ld_ready, md_ready, stall_req, we1, we2;
   logic [4:0]  waddr1, waddr2;
   logic [31:0] wdata1, wdata2;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .p0_we(p0_we), .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
      .p1_we(p1_we), .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
      .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wdata(md_wdata),
      .stall_req(stall_req),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .we2(we2), .waddr2(waddr2), .wdata2(wdata2)
   );

   typedef struct packed {
      logic        we1; logic [4:0] a1; logic [31:0] d1;
      logic        we2; logic [4:0] a2; logic [31:0] d2;
      logic        st;
   } obs_t;
   typedef struct packed { logic [4:0] a; logic [31:0] d; } w_t;

   obs_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] m_rf[32];
   logic [31:0] d_rf[32];
   int          m_cnt;
   bit          m_ptr, m_stall;
   bit          exp_ld, exp_md, ld_x, md_x, st_x;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   // Reference: pipe first (unless stalled), leftover ports shared by the
   // async sources, alternating on contention; writes listed ld, md, p0, p1
   // fill port 1 then port 2. Starved cycles count toward a forced stall.
   task automatic model_step();
      w_t   wl[$];
      obs_t e;
      bit   pa0, pa1, p0w, p1w, lz, mz, lr, mr, gl, gm, st_n;
      int   free;
      e = '0;
      if (rst) begin
         exp_ld = 0; exp_md = 0; m_cnt = 0; m_ptr = 0; m_stall = 0;
         exp_q.push_back(e);
         return;
      end
      pa0 = p0_we && !m_stall;
      pa1 = p1_we && !m_stall;
      p0w = pa0 && !(FILT && p0_waddr == 0);
      p1w = pa1 && !(FILT && p1_waddr == 0);
      lz  = FILT && ld_valid && ld_waddr == 0;
      mz  = FILT && md_valid && md_waddr == 0;
      lr  = ld_valid && !lz;
      mr  = md_valid && !mz;
      free = 2 - int'(p0w) - int'(p1w);
      gl = 0; gm = 0;
      if (lr && mr && free == 1) begin
         if (!m_ptr) gl = 1; else gm = 1;
         m_ptr = !m_ptr;
      end else if (free > 0) begin
         gl = lr; gm = mr;
      end
      exp_ld = gl || lz;
      exp_md = gm || mz;
      if (gl)  wl.push_back({ld_waddr, ld_wdata});
      if (gm)  wl.push_back({md_waddr, md_wdata});
      if (p0w) wl.push_back({p0_waddr, p0_wdata});
      if (p1w) wl.push_back({p1_waddr, p1_wdata});
      if (wl.size() > 0) begin
         e.we1 = 1; e.a1 = wl[0].a; e.d1 = wl[0].d; m_rf[wl[0].a] = wl[0].d;
      end
      if (wl.size() > 1) begin
         e.we2 = 1; e.a2 = wl[1].a; e.d2 = wl[1].d; m_rf[wl[1].a] = wl[1].d;
      end
      st_n = 0;
      if ((ld_valid || md_valid) && !(exp_ld || exp_md)) begin
         if (m_cnt + 1 == LIMIT) begin st_n = 1; m_cnt = 0; end
         else m_cnt++;
      end else begin
         m_cnt = 0;
      end
      e.st = st_n;
      m_stall = st_n;
      exp_q.push_back(e);
   endtask

   // Monitor: compares registered outputs against the queued expectation
   // and applies the DUT's writes to a bench-side register file.
   always @(posedge clk) begin
      obs_t e, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {we1, waddr1, wdata1, we2, waddr2, wdata2, stall_req};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL ports: got we1=%0b a1=%0d d1=%h we2=%0b a2=%0d d2=%h st=%0b want we1=%0b a1=%0d d1=%h we2=%0b a2=%0d d2=%h st=%0b",
                     a.we1, a.a1, a.d1, a.we2, a.a2, a.d2, a.st,
                     e.we1, e.a1, e.d1, e.we2, e.a2, e.d2, e.st);
         end
      end
      if (we1 === 1'b1) d_rf[waddr1] = wdata1;
      if (we2 === 1'b1) d_rf[waddr2] = wdata2;
   end

   // One cycle: inputs were applied at the negedge; settle, predict, check
   // ready, note handshakes, and return at the next negedge.
   task automatic tick();
      #1;
      st_x = stall_req;
      model_step();
      chk("ld_ready", ld_ready, exp_ld);
      chk("md_ready", md_ready, exp_md);
      ld_x = ld_valid & ld_ready;
      md_x = md_valid & md_ready;
      @(negedge clk);
   endtask

   // Async sources keep a request until it transfers, then maybe issue another.
   task automatic src_update(input int lp, input int mp);
      if (!ld_valid || ld_x) begin
         ld_valid = ($urandom_range(99) < lp);
         ld_waddr = 5'($urandom_range(31)); ld_wdata = $urandom;
      end
      if (!md_valid || md_x) begin
         md_valid = ($urandom_range(99) < mp);
         md_waddr = 5'($urandom_range(31)); md_wdata = $urandom;
      end
   endtask

   // The pipe re-presents its writes after a stall cycle.
   task automatic pipe_update(input int pp);
      if (!st_x) begin
         p0_we = ($urandom_range(99) < pp); p0_waddr = 5'($urandom_range(31)); p0_wdata = $urandom;
         p1_we = ($urandom_range(99) < pp); p1_waddr = 5'($urandom_range(31)); p1_wdata = $urandom;
      end
   endtask

   task automatic drain();
      p0_we = 0; p1_we = 0;
      repeat (3) begin tick(); src_update(0, 0); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
      m_cnt = 0; m_ptr = 0; m_stall = 0; ld_x = 0; md_x = 0; st_x = 0;
      rst = 1;
      p0_we = 0; p0_waddr = 0; p0_wdata = 0;
      p1_we = 0; p1_waddr = 0; p1_wdata = 0;
      ld_valid = 1; ld_waddr = 5'd7; ld_wdata = 32'h0000_a5a5;
      md_valid = 0; md_waddr = 0; md_wdata = 0;
      @(negedge clk);

      // Reset holds ld off and outputs low; first free cycle grants ld.
      repeat (2) begin
         chk("rst_we1", we1, 0); chk("rst_we2", we2, 0); chk("rst_stall", stall_req, 0);
         tick();
      end
      rst = 0;
      tick();
      chk("post_rst_ldx", ld_x, 1);
      chk("post_rst_we1", we1, 1);
      chk("post_rst_waddr1", waddr1, 7);
      chk("post_rst_wdata1", wdata1, 32'h0000_a5a5);
      ld_valid = 0;

      // Two pipe writes to r3: younger lands last.
      p0_we = 1; p0_waddr = 3; p0_wdata = 32'h11;
      p1_we = 1; p1_waddr = 3; p1_wdata = 32'h22;
      tick();
      chk("r3_wdata1", wdata1, 32'h11);
      chk("r3_wdata2", wdata2, 32'h22);
      p0_we = 0; p1_we = 0;
      tick();
      chk("r3_rf", d_rf[3], 32'h22);

      // One free port, both async sources busy: ld, md, ld.
      p0_we = 1;
      ld_valid = 1; ld_waddr = 5'd9;  ld_wdata = $urandom;
      md_valid = 1; md_waddr = 5'd10; md_wdata = $urandom;
      for (int k = 0; k < 3; k++) begin
         p0_waddr = 5'(k + 1); p0_wdata = $urandom;
         tick();
         chk("alt_ld", ld_x, (k % 2) == 0);
         chk("alt_md", md_x, (k % 2) == 1);
         src_update(100, 100);
      end
      drain();

      // Full pipe starves ld: stall on the 5th cycle, then again 5 later.
      ld_valid = 1; ld_waddr = 5'd12; ld_wdata = $urandom;
      st_x = 0;
      for (int c = 1; c <= 10; c++) begin
         if (!st_x) begin
            p0_we = 1; p0_waddr = 5'($urandom_range(1, 31)); p0_wdata = $urandom;
            p1_we = 1; p1_waddr = 5'($urandom_range(1, 31)); p1_wdata = $urandom;
         end
         tick();
         chk("starve_stall", st_x, (c == 5) || (c == 10));
         if (c == 5) chk("starve_ldx", ld_x, 1);
         src_update(100, 0);
      end
      drain();

      // ld and md both to r5: md on port 2 and persists.
      ld_valid = 1; ld_waddr = 5; ld_wdata = 32'haaaa_0005;
      md_valid = 1; md_waddr = 5; md_wdata = 32'hbbbb_0005;
      tick();
      chk("r5_ldx", ld_x, 1);
      chk("r5_mdx", md_x, 1);
      ld_valid = 0; md_valid = 0;
      chk("r5_waddr1", waddr1, 5);
      chk("r5_wdata1", wdata1, 32'haaaa_0005);
      chk("r5_waddr2", waddr2, 5);
      chk("r5_wdata2", wdata2, 32'hbbbb_0005);
      tick();
      chk("r5_rf", d_rf[5], 32'hbbbb_0005);

      // Random traffic with occasional mid-run reset.
      repeat (600) begin
         rst = ($urandom_range(99) < 2);
         pipe_update(55);
         tick();
         src_update(45, 45);
      end
      rst = 0;
      repeat (4) begin
         p0_we = 0; p1_we = 0;
         tick();
         src_update(0, 0);
      end

      chk("queue_drained", exp_q.size(), 0);
      for (int i = 1; i < 32; i++) chk("rf_final", d_rf[i], m_rf[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Schedules the two register-file write ports among four writeback sources:
  - pipe slot 0 (older in-order instruction);
  - pipe slot 1 (younger);
  - load-miss return (ld);
  - mult/div unit GPR result (md).
- Pipe writes have strict priority and never wait. Async sources use valid/ready and share any leftover ports round-robin.
- A starvation counter forces a one-cycle pipeline stall so async results always drain.
- Sits between the WB stage / async units and the 2W4R register file.

Parameters:
- STARVE_LIMIT, 4: consecutive denied async cycles before stall_req fires; legal range 1..15.
- CNT_W, 4: width of the starvation counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- p0_we  in  1  slot-0 write request
- p0_waddr  in  5  slot-0 destination register
- p0_wdata  in  32  slot-0 data
- p1_we  in  1  slot-1 write request
- p1_waddr  in  5  slot-1 destination register
- p1_wdata  in  32  slot-1 data
- ld_valid  in  1  load-return write request
- ld_ready  out  1  load-return write accepted this cycle
- ld_waddr  in  5  load-return destination register
- ld_wdata  in  32  load-return data
- md_valid  in  1  mult/div write request
- md_ready  out  1  mult/div write accepted this cycle
- md_waddr  in  5  mult/div destination register
- md_wdata  in  32  mult/div data
- stall_req  out  1  registered; pipeline holds its WB writes this cycle
- we1  out  1  registered regfile write port 1 enable (older write)
- waddr1  out  5  registered port 1 address
- wdata1  out  32  registered port 1 data
- we2  out  1  registered regfile write port 2 enable (younger write; wins on WAW)
- waddr2  out  5  registered port 2 address
- wdata2  out  32  registered port 2 data

Behaviour:
- Reset, synchronous: we1, we2, stall_req = 0; waddr/wdata = 0; starvation counter = 0; RR pointer = ld. ld_ready and md_ready are forced to 0 while rst = 1.
- Async handshake:
  - Transfer occurs when valid & ready.
  - ready is combinational from the valid signals and the current state. Requesters must not make valid depend on ready.
  - valid, waddr and wdata must be held until the transfer.
- Pipe acceptance:
  - When stall_req = 0, p0_we and p1_we are always accepted.
  - When stall_req = 1, both are ignored. The pipeline re-presents them the next cycle.
- Free ports = 2 minus the number of accepted pipe writes.
- Port mapping, decided in cycle t, driven on the output registers in cycle t+1 (latency 1):
  - p0 + p1: p0 on port 1, p1 on port 2.
  - One pipe write + one async: async on port 1, pipe on port 2.
  - Two asyncs: ld on port 1, md on port 2 (md wins if the addresses are equal).
  - A single async alone goes on port 1.
- Round robin:
  - Applies when exactly one port is free and both async sources are valid: grant the source named by the pointer.
  - After that grant the pointer flips to the other source.
  - An uncontended grant leaves the pointer unchanged.
- Starvation counter:
  - Increments each cycle in which (ld_valid | md_valid) & no async grant, saturating at STARVE_LIMIT.
  - Clears on any async grant, or when no async source is valid.
- stall_req:
  - Set to 1 in the next cycle when the counter reaches STARVE_LIMIT. The counter clears at the same moment.
  - Held for exactly one cycle. In that cycle both ports are free, so every valid async source is granted.
  - Never asserted in two consecutive cycles.
- If a pipe write and an async write target the same register in one cycle, the pipe write goes on port 2 and overrides. The scoreboard normally prevents this case.
- The arbiter does not filter address 0; the regfile ignores writes to $0.
- When rst asserts mid-operation, pending async requests are neither granted nor lost. They are re-arbitrated after reset.

Optional Feature:
- Macro: WB_ZERO_FILTER_EN.
- Defined: any request with waddr = 0 is accepted (ready = 1 for async, silently consumed for pipe) without occupying a port or driving we. It also does not clear or increment the starvation counter beyond normal grant rules; it counts as a grant.
- Undefined: requests to register 0 consume ports like any other write.

Decomposition:
- Shared constants stay in defines.v: RegAddrBus, RegBus, NOPRegAddr, WriteEnable/WriteDisable, RstEnable, ZeroWord.
- Add StarveLimitDefault to defines.v.
- One sub-module: rr_arb2, a 2-requester round-robin arbiter with a pointer flop and a grant-when-one-slot flag.

Test Plan:
- Reset with ld_valid = 1 → ld_ready = 0 during rst, all outputs 0. First cycle after rst: ld_ready = 1, and next cycle we1 = 1 with ld waddr/wdata.
- p0_we (r3 = 0x11) + p1_we (r3 = 0x22) → next cycle waddr1 = 3 / wdata1 = 0x11 and waddr2 = 3 / wdata2 = 0x22; regfile ends with r3 = 0x22.
- p0_we only, with ld_valid and md_valid both held → grants alternate ld, md, ld across the free port; pointer flips after each contended grant.
- p0 and p1 writing every cycle, ld_valid = 1 with STARVE_LIMIT = 4 → stall_req = 1 on the 5th cycle. In that cycle ld_ready = 1, and pipe writes are ignored and re-presented the next cycle. The counter returns to 0.
- ld (r5) and md (r5) with no pipe writes → we1/waddr1 = 5 with ld data, we2/waddr2 = 5 with md data; md value persists.
- WB_ZERO_FILTER_EN defined: p0_we to r0 plus ld_valid and md_valid → both asyncs granted in the same cycle, and no we is asserted for r0.
